multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle MIPS DataPath. Consumes opcode/func/zero from the datapath,
//  drives every mux select, register enable and ALU operation. One instruction = 2..5 cycles.
//  Sits beside DataPath in the CPU top; the two together form the complete core.
// PARAMETERS
//  ILLEGAL_TRAP  0  1: unknown opcode/func parks FSM in HALT until rst; 0: treated as NOP
// PORTS
//  clk             in   1  single clock, all state updates on rising edge
//  rst             in   1  synchronous reset, active-high
//  opcode          in   6  IR[31:26] from DataPath
//  func            in   6  IR[5:0] from DataPath
//  zero            in   1  ALU zero flag, combinational, same cycle
//  reg_dst         out  2  0=rt 1=rd 2=r31
//  mem_to_reg      out  2  0=ALUOut 1=MDR 2=PC
//  pc_src          out  2  0=ALU result 1=jump target 2=ALUOut 3=A
//  ALU_srcA        out  1  0=PC 1=A
//  ALU_srcB        out  2  0=B 1=const 4 2=sign-ext imm 3=sign-ext imm<<2
//  alu_op          out  3  ADD=010 SUB=110 AND=000 OR=001 SLT=111
//  IorD            out  1  0=PC 1=ALUOut as memory address
//  reg_write, mem_read, mem_write, IR_write, pc_write_input   out 1 each
//  instr_done      out  1  1-cycle pulse in final state of every instruction
//  illegal         out  1  1-cycle pulse in DECODE on unsupported opcode/func
// BEHAVIOUR
//  - Moore outputs decoded from state; pc_write_input additionally uses zero in BRANCH.
//  - Default in every state: all enables 0, all selects 0, alu_op=ADD.
//  - rst=1: state<=FETCH at edge; all enables, instr_done and illegal forced 0 while rst high.
//    Reset mid-instruction aborts it; first post-reset cycle is FETCH.
//  - FETCH: mem_read,IR_write,pc_write_input=1; IorD=0; srcA=0 srcB=1 ADD pc_src=0 -> DECODE
//  - DECODE: srcA=0 srcB=3 ADD (branch target into ALUOut). Next by opcode:
//    00(func 20/22/24/25/2A)->EXEC_R; 00(func 08)->JR; 23/2B->MEM_ADDR; 04/05->BRANCH;
//    08/0A->IMM_EXEC; 02->JUMP; 03->JAL; other -> illegal=1, FETCH (or HALT if ILLEGAL_TRAP)
//  - EXEC_R: srcA=1 srcB=0, alu_op from func (20 ADD,22 SUB,24 AND,25 OR,2A SLT) -> R_WB
//  - R_WB: reg_dst=1 mem_to_reg=0 reg_write=1 -> FETCH
//  - MEM_ADDR: srcA=1 srcB=2 ADD -> MEM_READ (23) / MEM_WRITE (2B)
//  - MEM_READ: mem_read=1 IorD=1 -> MEM_WB;  MEM_WB: reg_dst=0 mem_to_reg=1 reg_write=1 -> FETCH
//  - MEM_WRITE: mem_write=1 IorD=1 -> FETCH
//  - BRANCH: srcA=1 srcB=0 SUB pc_src=2; pc_write_input = zero (04) / ~zero (05) -> FETCH
//  - IMM_EXEC: srcA=1 srcB=2, ADD (08) / SLT (0A) -> IMM_WB; IMM_WB: reg_dst=0 mem_to_reg=0
//    reg_write=1 -> FETCH
//  - JUMP: pc_src=1 pc_write_input=1 -> FETCH
//  - JAL: pc_src=1 pc_write_input=1 reg_dst=2 mem_to_reg=2 reg_write=1 (writes PC+4, PC
//    updates same edge) -> FETCH
//  - JR: pc_src=3 pc_write_input=1 -> FETCH
//  - HALT: all enables 0, stays until rst.
//  - instr_done=1 in R_WB, MEM_WB, MEM_WRITE, BRANCH, IMM_WB, JUMP, JAL, JR.
//  - Cycle counts incl. FETCH: R/addi/slti/sw 4, lw 5, beq/bne/j/jal/jr 3, illegal 2.
//  - mem_read and mem_write never both 1; reg_write never 1 in FETCH/DECODE.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: state enum, opcode/func localparams, alu_op codes,
//    select encodings for reg_dst/mem_to_reg/pc_src/ALU_srcB.
//  - One sub-module: alu_func_decoder (func -> alu_op, valid flag), used by EXEC_R and DECODE.
//  - State register + next-state block + output decode block in this module.
// TESTING
//  - rst held 3 cycles then released -> cycle 1 FETCH: mem_read=IR_write=pc_write_input=1.
//  - add (op 00, func 20) -> states FETCH,DECODE,EXEC_R,R_WB; alu_op=010, reg_dst=1, done pulse.
//  - lw (op 23) -> 5 cycles; MEM_READ IorD=1 mem_read=1; MEM_WB mem_to_reg=1 reg_write=1.
//  - beq (04) zero=1 -> pc_write_input=1 pc_src=2 in BRANCH; bne (05) zero=1 -> pc_write_input=0.
//  - jal (03) -> JAL cycle: reg_dst=2 mem_to_reg=2 reg_write=1 pc_src=1; jr (00/08) pc_src=3.
//  - op 3F -> illegal pulse, FETCH next (TRAP=0) / HALT held (TRAP=1); rst in MEM_READ -> FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - state_e       : control FSM states
//   - Op*/Func*     : opcode (IR[31:26]) and R-type func (IR[5:0]) values handled by the core
//   - Alu*          : ALU operation codes driven on alu_op
//   - RegDst*, MemToReg*, PcSrc*, SrcA*, SrcB* : datapath mux select encodings
//   - is_final_state: true for the last state of every instruction (drives instr_done)
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StRWb,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StBranch,
    StImmExec,
    StImmWb,
    StJump,
    StJal,
    StJr,
    StHalt
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type func codes
  localparam logic [5:0] FuncJr  = 6'h08;
  localparam logic [5:0] FuncAdd = 6'h20;
  localparam logic [5:0] FuncSub = 6'h22;
  localparam logic [5:0] FuncAnd = 6'h24;
  localparam logic [5:0] FuncOr  = 6'h25;
  localparam logic [5:0] FuncSlt = 6'h2A;

  // ALU operations
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // Register file write address select
  localparam logic [1:0] RegDstRt  = 2'd0;
  localparam logic [1:0] RegDstRd  = 2'd1;
  localparam logic [1:0] RegDstR31 = 2'd2;

  // Register file write data select
  localparam logic [1:0] MemToRegAlu = 2'd0;
  localparam logic [1:0] MemToRegMdr = 2'd1;
  localparam logic [1:0] MemToRegPc  = 2'd2;

  // Next-PC select
  localparam logic [1:0] PcSrcAluRes = 2'd0;
  localparam logic [1:0] PcSrcJump   = 2'd1;
  localparam logic [1:0] PcSrcAluOut = 2'd2;
  localparam logic [1:0] PcSrcRegA   = 2'd3;

  // ALU operand selects
  localparam logic       SrcAPc    = 1'b0;
  localparam logic       SrcARegA  = 1'b1;
  localparam logic [1:0] SrcBRegB  = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  function automatic logic is_final_state(state_e s);
    case (s)
      StRWb, StMemWb, StMemWrite, StBranch, StImmWb, StJump, StJal, StJr: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_func_decoder.sv
// R-type func field decoder.
//   func_i   : IR[5:0]
//   alu_op_o : ALU operation for the arithmetic/logic R-type instructions (ADD when invalid)
//   valid_o  : func_i is one of add/sub/and/or/slt
// jr is not an ALU instruction and is recognised separately by the controller.
module alu_func_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [2:0] alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = AluAdd;
    valid_o  = 1'b1;
    case (func_i)
      FuncAdd: alu_op_o = AluAdd;
      FuncSub: alu_op_o = AluSub;
      FuncAnd: alu_op_o = AluAnd;
      FuncOr:  alu_op_o = AluOr;
      FuncSlt: alu_op_o = AluSlt;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath. Each instruction takes 2..5 cycles, starting in
// FETCH; every datapath select, enable and ALU operation is decoded from the current state.
// Parameters:
//   ILLEGAL_TRAP : 1 = unknown opcode/func parks the FSM in HALT until rst, 0 = treated as NOP
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   opcode, func, zero       : IR[31:26], IR[5:0], ALU zero flag (same cycle) from the datapath
//   reg_dst, mem_to_reg      : register-file write address / data selects
//   pc_src                   : next-PC select
//   ALU_srcA, ALU_srcB       : ALU operand selects
//   alu_op                   : ALU operation
//   IorD                     : memory address select (0 = PC, 1 = ALUOut)
//   reg_write, mem_read, mem_write, IR_write, pc_write_input : datapath enables
//   instr_done               : pulse in the final state of every instruction
//   illegal                  : pulse in DECODE on an unsupported opcode/func
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_src,
  output logic       ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [2:0] alu_op,
  output logic       IorD,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IR_write,
  output logic       pc_write_input,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [2:0] func_alu_op;
  logic       func_alu_valid;
  logic       decode_illegal;

  alu_func_decoder u_alu_func_decoder (
    .func_i   (func),
    .alu_op_o (func_alu_op),
    .valid_o  (func_alu_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    decode_illegal = 1'b0;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype: begin
            if (func_alu_valid) begin
              state_d = StExecR;
            end else if (func == FuncJr) begin
              state_d = StJr;
            end else begin
              decode_illegal = 1'b1;
            end
          end
          OpLw, OpSw:     state_d = StMemAddr;
          OpBeq, OpBne:   state_d = StBranch;
          OpAddi, OpSlti: state_d = StImmExec;
          OpJ:            state_d = StJump;
          OpJal:          state_d = StJal;
          default:        decode_illegal = 1'b1;
        endcase
        if (decode_illegal) begin
          state_d = ILLEGAL_TRAP ? StHalt : StFetch;
        end
      end
      StExecR:   state_d = StRWb;
      StMemAddr: state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead: state_d = StMemWb;
      StImmExec: state_d = StImmWb;
      StHalt:    state_d = StHalt;
      // Every remaining state is the final cycle of an instruction.
      default:   state_d = StFetch;
    endcase
  end

  // Output decode
  always_comb begin
    reg_dst        = RegDstRt;
    mem_to_reg     = MemToRegAlu;
    pc_src         = PcSrcAluRes;
    ALU_srcA       = SrcAPc;
    ALU_srcB       = SrcBRegB;
    alu_op         = AluAdd;
    IorD           = 1'b0;
    reg_write      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    IR_write       = 1'b0;
    pc_write_input = 1'b0;
    instr_done     = is_final_state(state_q);
    illegal        = decode_illegal;

    unique case (state_q)
      StFetch: begin
        mem_read       = 1'b1;
        IR_write       = 1'b1;
        pc_write_input = 1'b1;
        ALU_srcB       = SrcBFour;
      end
      // Speculatively form the branch target into ALUOut.
      StDecode: ALU_srcB = SrcBImmSh;
      StExecR: begin
        ALU_srcA = SrcARegA;
        alu_op   = func_alu_op;
      end
      StRWb: begin
        reg_dst   = RegDstRd;
        reg_write = 1'b1;
      end
      StMemAddr: begin
        ALU_srcA = SrcARegA;
        ALU_srcB = SrcBImm;
      end
      StMemRead: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = MemToRegMdr;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      StBranch: begin
        ALU_srcA       = SrcARegA;
        alu_op         = AluSub;
        pc_src         = PcSrcAluOut;
        pc_write_input = (opcode == OpBne) ? ~zero : zero;
      end
      StImmExec: begin
        ALU_srcA = SrcARegA;
        ALU_srcB = SrcBImm;
        alu_op   = (opcode == OpSlti) ? AluSlt : AluAdd;
      end
      StImmWb: reg_write = 1'b1;
      StJump: begin
        pc_src         = PcSrcJump;
        pc_write_input = 1'b1;
      end
      // Register file captures PC+4 on the same edge the PC takes the jump target.
      StJal: begin
        pc_src         = PcSrcJump;
        pc_write_input = 1'b1;
        reg_dst        = RegDstR31;
        mem_to_reg     = MemToRegPc;
        reg_write      = 1'b1;
      end
      StJr: begin
        pc_src         = PcSrcRegA;
        pc_write_input = 1'b1;
      end
      default: ;
    endcase

    // Reset suppresses every side effect; selects are left as decoded.
    if (rst) begin
      reg_write      = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      IR_write       = 1'b0;
      pc_write_input = 1'b0;
      instr_done     = 1'b0;
      illegal        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu_op;
    logic       iord;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       done;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero;

  logic [1:0] m_reg_dst, m_mem_to_reg, m_pc_src, m_srcb;
  logic [2:0] m_alu_op;
  logic       m_srca, m_iord, m_reg_write, m_mem_read, m_mem_write, m_ir_write, m_pc_write;
  logic       m_done, m_illegal;
  logic [1:0] t_reg_dst, t_mem_to_reg, t_pc_src, t_srcb;
  logic [2:0] t_alu_op;
  logic       t_srca, t_iord, t_reg_write, t_mem_read, t_mem_write, t_ir_write, t_pc_write;
  logic       t_done, t_illegal;

  ctl_t obs_m, obs_t;
  assign obs_m = {m_reg_dst, m_mem_to_reg, m_pc_src, m_srca, m_srcb, m_alu_op, m_iord,
                  m_reg_write, m_mem_read, m_mem_write, m_ir_write, m_pc_write, m_done,
                  m_illegal};
  assign obs_t = {t_reg_dst, t_mem_to_reg, t_pc_src, t_srca, t_srcb, t_alu_op, t_iord,
                  t_reg_write, t_mem_read, t_mem_write, t_ir_write, t_pc_write, t_done,
                  t_illegal};

  int total = 0;
  int bad   = 0;

  ctl_t  exp_m_q[$];
  ctl_t  exp_t_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .func           (func),
    .zero           (zero),
    .reg_dst        (m_reg_dst),
    .mem_to_reg     (m_mem_to_reg),
    .pc_src         (m_pc_src),
    .ALU_srcA       (m_srca),
    .ALU_srcB       (m_srcb),
    .alu_op         (m_alu_op),
    .IorD           (m_iord),
    .reg_write      (m_reg_write),
    .mem_read       (m_mem_read),
    .mem_write      (m_mem_write),
    .IR_write       (m_ir_write),
    .pc_write_input (m_pc_write),
    .instr_done     (m_done),
    .illegal        (m_illegal)
  );

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) u_dut_trap (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .func           (func),
    .zero           (zero),
    .reg_dst        (t_reg_dst),
    .mem_to_reg     (t_mem_to_reg),
    .pc_src         (t_pc_src),
    .ALU_srcA       (t_srca),
    .ALU_srcB       (t_srcb),
    .alu_op         (t_alu_op),
    .IorD           (t_iord),
    .reg_write      (t_reg_write),
    .mem_read       (t_mem_read),
    .mem_write      (t_mem_write),
    .IR_write       (t_ir_write),
    .pc_write_input (t_pc_write),
    .instr_done     (t_done),
    .illegal        (t_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: one expected vector per cycle for each controller, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_m_q.size() != 0) begin
      ctl_t  em, et;
      string tg;
      em = exp_m_q.pop_front();
      et = exp_t_q.pop_front();
      tg = tag_q.pop_front();
      check(tg, 32'(obs_m), 32'(em));
      check({"trap_", tg}, 32'(obs_t), 32'(et));
    end
  end

  // Idle / HALT vector: no enables, zero selects, ALU add.
  function automatic ctl_t base();
    ctl_t c;
    c        = '0;
    c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctl_t fetch_vec();
    ctl_t c;
    c          = base();
    c.mem_read = 1'b1;
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    c.srcb     = 2'd1;
    return c;
  endfunction

  // FETCH selects with enables suppressed by reset.
  function automatic ctl_t rst_fetch_vec();
    ctl_t c;
    c      = base();
    c.srcb = 2'd1;
    return c;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Queue one cycle of expectations; the trap instance sits in HALT when trap_halted is set.
  task automatic step(input string tag, input ctl_t e, input bit trap_halted);
    exp_m_q.push_back(e);
    exp_t_q.push_back(trap_halted ? base() : e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input bit th);
    ctl_t e;
    bit   is_r;
    opcode = op;
    func   = fn;
    zero   = z;
    is_r   = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
    step({name, ":fetch"}, fetch_vec(), th);
    e      = base();
    e.srcb = 2'd3;
    if ((op == 6'h00 && !is_r && fn != 6'h08) ||
        !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B})) begin
      e.illegal = 1'b1;
      step({name, ":decode"}, e, th);
      return;
    end
    step({name, ":decode"}, e, th);
    e = base();
    case (op)
      6'h00: begin
        if (is_r) begin
          e.srca   = 1'b1;
          e.alu_op = r_alu(fn);
          step({name, ":exec"}, e, th);
          e           = base();
          e.reg_dst   = 2'd1;
          e.reg_write = 1'b1;
          e.done      = 1'b1;
          step({name, ":wb"}, e, th);
        end else begin
          e.pc_src   = 2'd3;
          e.pc_write = 1'b1;
          e.done     = 1'b1;
          step({name, ":jr"}, e, th);
        end
      end
      6'h23, 6'h2B: begin
        e.srca = 1'b1;
        e.srcb = 2'd2;
        step({name, ":addr"}, e, th);
        e      = base();
        e.iord = 1'b1;
        if (op == 6'h23) begin
          e.mem_read = 1'b1;
          step({name, ":read"}, e, th);
          e            = base();
          e.mem_to_reg = 2'd1;
          e.reg_write  = 1'b1;
          e.done       = 1'b1;
          step({name, ":wb"}, e, th);
        end else begin
          e.mem_write = 1'b1;
          e.done      = 1'b1;
          step({name, ":write"}, e, th);
        end
      end
      6'h04, 6'h05: begin
        e.srca     = 1'b1;
        e.alu_op   = 3'b110;
        e.pc_src   = 2'd2;
        e.pc_write = (op == 6'h04) ? z : ~z;
        e.done     = 1'b1;
        step({name, ":branch"}, e, th);
      end
      6'h08, 6'h0A: begin
        e.srca   = 1'b1;
        e.srcb   = 2'd2;
        e.alu_op = (op == 6'h0A) ? 3'b111 : 3'b010;
        step({name, ":exec"}, e, th);
        e           = base();
        e.reg_write = 1'b1;
        e.done      = 1'b1;
        step({name, ":wb"}, e, th);
      end
      6'h02, 6'h03: begin
        e.pc_src   = 2'd1;
        e.pc_write = 1'b1;
        e.done     = 1'b1;
        if (op == 6'h03) begin
          e.reg_dst    = 2'd2;
          e.mem_to_reg = 2'd2;
          e.reg_write  = 1'b1;
        end
        step({name, ":jump"}, e, th);
      end
      default: ;
    endcase
  endtask

  initial begin
    ctl_t e;
    rst    = 1'b1;
    opcode = 6'h00;
    func   = 6'h20;
    zero   = 1'b0;
    // Three reset edges; state is unknown before the first.
    @(posedge clk);
    #1;
    step("rst1", rst_fetch_vec(), 1'b0);
    step("rst2", rst_fetch_vec(), 1'b0);
    rst = 1'b0;

    run_instr("add",  6'h00, 6'h20, 1'b0, 1'b0);
    run_instr("sub",  6'h00, 6'h22, 1'b1, 1'b0);
    run_instr("and",  6'h00, 6'h24, 1'b0, 1'b0);
    run_instr("or",   6'h00, 6'h25, 1'b0, 1'b0);
    run_instr("slt",  6'h00, 6'h2A, 1'b1, 1'b0);
    run_instr("lw",   6'h23, 6'h11, 1'b0, 1'b0);
    run_instr("sw",   6'h2B, 6'h00, 1'b1, 1'b0);
    run_instr("beq1", 6'h04, 6'h00, 1'b1, 1'b0);
    run_instr("beq0", 6'h04, 6'h00, 1'b0, 1'b0);
    run_instr("bne1", 6'h05, 6'h00, 1'b1, 1'b0);
    run_instr("bne0", 6'h05, 6'h00, 1'b0, 1'b0);
    run_instr("addi", 6'h08, 6'h2A, 1'b0, 1'b0);
    run_instr("slti", 6'h0A, 6'h20, 1'b0, 1'b0);
    run_instr("j",    6'h02, 6'h00, 1'b0, 1'b0);
    run_instr("jal",  6'h03, 6'h00, 1'b0, 1'b0);
    run_instr("jr",   6'h00, 6'h08, 1'b0, 1'b0);
    run_instr("op3f", 6'h3F, 6'h00, 1'b0, 1'b0);
    // Trap instance is now parked in HALT.
    run_instr("add_h",  6'h00, 6'h20, 1'b0, 1'b1);
    run_instr("fn3f_h", 6'h00, 6'h3F, 1'b0, 1'b1);
    run_instr("jal_h",  6'h03, 6'h00, 1'b0, 1'b1);

    // Reset recovers the trapped instance.
    rst = 1'b1;
    step("rst_rec1", rst_fetch_vec(), 1'b1);
    step("rst_rec2", rst_fetch_vec(), 1'b0);
    rst = 1'b0;
    run_instr("sw_rec", 6'h2B, 6'h00, 1'b0, 1'b0);

    // Reset during MEM_READ aborts the load.
    opcode = 6'h23;
    func   = 6'h00;
    step("lw_abort:fetch", fetch_vec(), 1'b0);
    e      = base();
    e.srcb = 2'd3;
    step("lw_abort:decode", e, 1'b0);
    e      = base();
    e.srca = 1'b1;
    e.srcb = 2'd2;
    step("lw_abort:addr", e, 1'b0);
    rst    = 1'b1;
    e      = base();
    e.iord = 1'b1;
    step("lw_abort:rst", e, 1'b0);
    rst = 1'b0;
    run_instr("lw_after", 6'h23, 6'h00, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("drain", 32'(exp_m_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
